// File: rtl/mv_search_ctrl.sv
// mv_search_ctrl
//   Sequences one block-match search over NUM_ROWS candidate columns (x offsets).
//   Each column is requested from the SAD array. The column minimum (SAD and y
//   index) comes back from the external compare tree in issue order. A running
//   window minimum is kept and presented on a valid/ready result port.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   start                     1-cycle pulse; begins a search, honoured only in IDLE
//   flush                     synchronous abort back to IDLE
//   row_req/row_idx/row_gnt   column request handshake to the SAD array
//   cmp_valid/cmp_sad/cmp_mv_y  column minimum returned by the compare tree
//   busy                      search in progress or result pending
//   res_valid/res_ready       result handshake
//   best_sad/best_mv_x/best_mv_y  window minimum and its position
module mv_search_ctrl #(
    parameter int SAD_W    = 14,
    parameter int MVY_W    = 4,
    parameter int MVX_W    = 4,
    parameter int NUM_ROWS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    output logic             row_req,
    output logic [MVX_W-1:0] row_idx,
    input  logic             row_gnt,
    input  logic             cmp_valid,
    input  logic [SAD_W-1:0] cmp_sad,
    input  logic [MVY_W-1:0] cmp_mv_y,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SAD_W-1:0] best_sad,
    output logic [MVX_W-1:0] best_mv_x,
    output logic [MVY_W-1:0] best_mv_y
);

    // One extra bit so the counters can reach NUM_ROWS itself.
    localparam int CNT_W = MVX_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] iss_cnt, rcv_cnt;
    logic             first_flag;
    logic             issue, capture, take_best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_req   = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        take_best = 1'b0;

        if (state == S_RUN) begin
            row_req = (iss_cnt < LAST);
            issue   = row_req & row_gnt;
            // A result with nothing outstanding is a protocol error and is dropped.
            capture = cmp_valid & (rcv_cnt < iss_cnt);
            // Strict less-than: on a tie the earlier column keeps the minimum.
            take_best = capture & (first_flag | (cmp_sad < best_sad));
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (capture && (rcv_cnt == LAST - ONE)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign row_idx   = iss_cnt[MVX_W-1:0];
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_cnt    <= '0;
            rcv_cnt    <= '0;
            first_flag <= 1'b1;
            best_sad   <= '0;
            best_mv_x  <= '0;
            best_mv_y  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        iss_cnt    <= '0;
                        rcv_cnt    <= '0;
                        first_flag <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        iss_cnt <= '0;
                        rcv_cnt <= '0;
                    end else begin
                        if (issue) begin
                            iss_cnt <= iss_cnt + ONE;
                        end
                        if (capture) begin
                            rcv_cnt <= rcv_cnt + ONE;
                        end
                        if (take_best) begin
                            best_sad   <= cmp_sad;
                            best_mv_x  <= rcv_cnt[MVX_W-1:0];
                            best_mv_y  <= cmp_mv_y;
                            first_flag <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        iss_cnt <= '0;
                        rcv_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mv_search_ctrl.sv
// tb_mv_search_ctrl
//   Directed bench for mv_search_ctrl. An SAD-array/compare-tree responder
//   returns per-column table values after a programmable latency. A search-level
//   model (counts of issued/received columns, argmin over received values) is
//   compared against the DUT outputs on every falling edge. Literal expectations
//   pin each scenario's final result.
module tb_mv_search_ctrl;

    localparam int SAD_W = 14;
    localparam int MVY_W = 4;
    localparam int MVX_W = 4;
    localparam int N     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start, flush, row_gnt, res_ready;
    logic             row_req, cmp_valid, busy, res_valid;
    logic [MVX_W-1:0] row_idx, best_mv_x;
    logic [SAD_W-1:0] cmp_sad, best_sad;
    logic [MVY_W-1:0] cmp_mv_y, best_mv_y;

    mv_search_ctrl #(
        .SAD_W   (SAD_W),
        .MVY_W   (MVY_W),
        .MVX_W   (MVX_W),
        .NUM_ROWS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .row_req  (row_req),
        .row_idx  (row_idx),
        .row_gnt  (row_gnt),
        .cmp_valid(cmp_valid),
        .cmp_sad  (cmp_sad),
        .cmp_mv_y (cmp_mv_y),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .best_sad (best_sad),
        .best_mv_x(best_mv_x),
        .best_mv_y(best_mv_y)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Column tables served by the responder.
    int tbl_sad[N];
    int tbl_y[N];
    int latency = 2;

    // Responder state: outstanding columns and the cycle each may return.
    int q_col[$];
    int q_rdy[$];
    int cyc = 0;
    bit err_pulse = 1'b0;
    int n_issued = 0;
    bit smp_req = 1'b0;
    int smp_idx = 0;

    // Search-level model.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_iss = 0;
    int m_rcv = 0;
    int r_sad[N];
    int r_y[N];
    int m_bsad = 0;
    int m_bx = 0;
    int m_by = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pick_best();
        m_bx = 0;
        for (int k = 1; k < m_rcv; k++) begin
            if (r_sad[k] < r_sad[m_bx]) m_bx = k;
        end
        m_bsad = r_sad[m_bx];
        m_by   = r_y[m_bx];
    endtask

    // Model and issue observer, advanced on each active edge (or async reset).
    initial begin : model_p
        bit exp_req;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_iss = 0; m_rcv = 0;
                m_bsad = 0; m_bx = 0; m_by = 0;
                q_col.delete(); q_rdy.delete();
            end else begin
                cyc++;
                if (smp_req && row_gnt) begin
                    q_col.push_back(smp_idx);
                    q_rdy.push_back(cyc + latency - 1);
                    n_issued++;
                end
                exp_req = m_busy && !m_done && (m_iss < N);
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1'b1; m_iss = 0; m_rcv = 0;
                    end
                end else if (flush) begin
                    m_busy = 1'b0; m_done = 1'b0; m_iss = 0; m_rcv = 0;
                end else if (m_done) begin
                    if (res_ready) begin
                        m_busy = 1'b0; m_done = 1'b0;
                    end
                end else begin
                    if (cmp_valid && (m_rcv < m_iss)) begin
                        r_sad[m_rcv] = int'(cmp_sad);
                        r_y[m_rcv]   = int'(cmp_mv_y);
                        m_rcv++;
                        pick_best();
                        if (m_rcv == N) m_done = 1'b1;
                    end
                    if (exp_req && row_gnt) m_iss++;
                end
            end
        end
    end

    // Compare against the model, then drive the responder outputs.
    initial begin : cmp_p
        bit exp_req;
        int c;
        cmp_valid = 1'b0; cmp_sad = '0; cmp_mv_y = '0;
        forever begin
            @(negedge clk);
            smp_req = row_req;
            smp_idx = int'(row_idx);
            exp_req = m_busy && !m_done && (m_iss < N);
            check("busy", int'(busy), int'(m_busy));
            check("res_valid", int'(res_valid), int'(m_done));
            check("row_req", int'(row_req), int'(exp_req));
            if (exp_req) check("row_idx", int'(row_idx), m_iss);
            check("best_sad", int'(best_sad), m_bsad);
            check("best_mv_x", int'(best_mv_x), m_bx);
            check("best_mv_y", int'(best_mv_y), m_by);

            cmp_valid = 1'b0; cmp_sad = '0; cmp_mv_y = '0;
            if (err_pulse) begin
                cmp_valid = 1'b1;
                err_pulse = 1'b0;
            end else if (q_rdy.size() > 0 && q_rdy[0] <= cyc) begin
                c = q_col.pop_front();
                void'(q_rdy.pop_front());
                cmp_valid = 1'b1;
                cmp_sad   = SAD_W'(tbl_sad[c]);
                cmp_mv_y  = MVY_W'(tbl_y[c]);
            end
        end
    end

    task automatic expect_best(input string name, input int s, input int x, input int y);
        check({name, "_sad"}, int'(best_sad), s);
        check({name, "_x"}, int'(best_mv_x), x);
        check({name, "_y"}, int'(best_mv_y), y);
    endtask

    task automatic run_search(input bit rand_gnt, input int hold, input bit strays,
                              input bit inject);
        int k;
        @(negedge clk);
        start = 1'b1;
        row_gnt = 1'b1;
        n_issued = 0;
        #1 err_pulse = inject;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!res_valid && k < 400) begin
            row_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
            start = strays && (k % 7 == 3);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        row_gnt = 1'b0;
        if (!res_valid) check("result_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            start = strays && (h == 4);
            @(negedge clk);
        end
        if (hold > 0) check("res_held", int'(res_valid), 1);
        // A start coinciding with the result handshake must not launch a search.
        start = strays;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_ready = 1'b0;
        check("issued", n_issued, N);
        check("idle_after", int'(busy), 0);
    endtask

    task automatic wait_rcv(input int n);
        int k = 0;
        while (m_rcv < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (m_rcv < n) check("rcv_timeout", m_rcv, n);
    endtask

    initial begin
        start = 1'b0; flush = 1'b0; row_gnt = 1'b0; res_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_row_req", int'(row_req), 0);
        check("rst_res_valid", int'(res_valid), 0);
        expect_best("rst", 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic: 100+x with a dip at column 5.
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 100 + x; tbl_y[x] = x; end
        tbl_sad[5] = 40; tbl_y[5] = 9;
        latency = 2;
        run_search(1'b0, 0, 1'b0, 1'b0);
        expect_best("basic", 40, 5, 9);

        // Tie between columns 3 and 11; stray early result must be ignored.
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 50; tbl_y[x] = (x + 1) & 15; end
        tbl_sad[3] = 7; tbl_sad[11] = 7;
        latency = 1;
        run_search(1'b0, 0, 1'b0, 1'b1);
        expect_best("tie", 7, 3, 4);

        // All-ones SADs: only the first-column load can set the minimum.
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 16'h3FFF; tbl_y[x] = 2; end
        latency = 4;
        run_search(1'b0, 0, 1'b0, 1'b0);
        expect_best("ones", 16'h3FFF, 0, 2);

        // Backpressure: random grants, held result, stray starts.
        for (int x = 0; x < N; x++) begin
            tbl_sad[x] = (x - 9) * (x - 9) * 5 + 60;
            tbl_y[x]   = (x * 7) & 15;
        end
        latency = 2;
        run_search(1'b1, 10, 1'b1, 1'b0);
        expect_best("bp", 60, 9, 15);

        // Flush after six results; in-flight results arrive in IDLE.
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 100 + x; tbl_y[x] = x; end
        tbl_sad[5] = 40; tbl_y[5] = 9;
        latency = 3;
        @(negedge clk);
        start = 1'b1; row_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rcv(6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        row_gnt = 1'b0;
        check("flush_busy", int'(busy), 0);
        check("flush_row_req", int'(row_req), 0);
        repeat (8) @(negedge clk);
        expect_best("flush_partial", 40, 5, 9);
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 1000 - 10 * x; tbl_y[x] = x ^ 5; end
        run_search(1'b0, 0, 1'b0, 1'b0);
        expect_best("post_flush", 850, 15, 10);

        // Asynchronous reset mid-search.
        for (int x = 0; x < N; x++) begin tbl_sad[x] = 20 + x; tbl_y[x] = 6; end
        latency = 2;
        @(negedge clk);
        start = 1'b1; row_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rcv(4);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_row_req", int'(row_req), 0);
        check("arst_row_idx", int'(row_idx), 0);
        check("arst_res_valid", int'(res_valid), 0);
        expect_best("arst", 0, 0, 0);
        row_gnt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_search(1'b0, 0, 1'b0, 1'b0);
        expect_best("post_rst", 20, 0, 6);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
